// File: rtl/slice_pkg.sv
// Shared range helpers and FSM state type for the slice streamer.
// Range bounds may be given in either order; these return the normalised bounds.
package slice_pkg;

    function automatic int range_lo(input int l, input int r);
        return (l < r) ? l : r;
    endfunction

    function automatic int range_hi(input int l, input int r);
        return (l < r) ? r : l;
    endfunction

    function automatic int range_len(input int l, input int r);
        return range_hi(l, r) - range_lo(l, r) + 1;
    endfunction

    typedef enum logic {IDLE, BUSY} stream_state_t;

endpackage

// File: rtl/slice_select.sv
// Combinational window select: returns slice k of a [LEFT:RIGHT] word,
// walking up from LO with +: or down from HI with -:. Output MSB is the window's highest index.
module slice_select
    import slice_pkg::*;
#(
    parameter int LEFT      = 7,
    parameter int RIGHT     = 0,
    parameter int SLICE_LEN = 2,
    parameter int HI_FIRST  = 0,
    localparam int KW       = $clog2(range_len(LEFT, RIGHT) / SLICE_LEN) + 1
) (
    input  logic [LEFT:RIGHT]     word,
    input  logic [KW-1:0]         k,
    output logic [SLICE_LEN-1:0]  slice
);

    localparam int LO  = range_lo(LEFT, RIGHT);
    localparam int HI  = range_hi(LEFT, RIGHT);
    localparam int NUM = range_len(LEFT, RIGHT) / SLICE_LEN;

    logic [SLICE_LEN-1:0] cand [NUM];

    for (genvar g = 0; g < NUM; g++) begin : g_win
        logic [SLICE_LEN-1:0] raw;
        logic [SLICE_LEN-1:0] win;

        if (HI_FIRST != 0) begin : g_down
            assign raw = word[HI - g*SLICE_LEN -: SLICE_LEN];
        end else begin : g_up
            assign raw = word[LO + g*SLICE_LEN +: SLICE_LEN];
        end

        // On an ascending range a part-select puts the lowest index at the MSB; flip it.
        for (genvar j = 0; j < SLICE_LEN; j++) begin : g_bit
            if (LEFT < RIGHT) begin : g_flip
                assign win[j] = raw[SLICE_LEN-1-j];
            end else begin : g_keep
                assign win[j] = raw[j];
            end
        end

        assign cand[g] = win;
    end

    always_comb begin
        slice = '0;
        for (int g = 0; g < NUM; g++) begin
            if (k == KW'(g)) slice = cand[g];
        end
    end

endmodule

// File: rtl/slice_streamer.sv
// Captures one [LEFT:RIGHT] word and streams it as NUM slices over valid/ready.
// Optional macro SLICE_STREAMER_PARITY_EN adds out_parity (XOR of out_data).
module slice_streamer
    import slice_pkg::*;
#(
    parameter int LEFT      = 7,
    parameter int RIGHT     = 0,
    parameter int SLICE_LEN = 2,
    parameter int HI_FIRST  = 0,
    localparam int KW       = $clog2(range_len(LEFT, RIGHT) / SLICE_LEN) + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [LEFT:RIGHT]     in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [SLICE_LEN-1:0]  out_data,
    output logic [KW-1:0]         out_index,
    output logic                  out_last
`ifdef SLICE_STREAMER_PARITY_EN
    ,
    output logic                  out_parity
`endif
);

    localparam int LEN = range_len(LEFT, RIGHT);
    localparam int NUM = LEN / SLICE_LEN;
    localparam logic [KW-1:0] K_LAST = KW'(NUM - 1);

    if (SLICE_LEN < 1 || (LEN % SLICE_LEN) != 0) begin : g_bad_slice_len
        $error("slice_streamer: SLICE_LEN must be >= 1 and divide the word length");
    end

    stream_state_t        state_q, state_d;
    logic [KW-1:0]        k_q, k_d;
    logic [LEFT:RIGHT]    data_q, data_d;
    logic                 busy_d;
    logic [SLICE_LEN-1:0] sel_slice;
    logic [SLICE_LEN-1:0] out_data_q, out_data_d;
    logic [KW-1:0]        out_index_q, out_index_d;
    logic                 out_last_q, out_last_d;

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        data_d  = data_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    data_d  = in_data;
                    k_d     = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (out_ready) begin
                    if (k_q == K_LAST) begin
                        k_d     = '0;
                        state_d = IDLE;
                    end else begin
                        k_d = k_q + KW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered from next-state values so they are glitch-free and hold while stalled.
    slice_select #(
        .LEFT      (LEFT),
        .RIGHT     (RIGHT),
        .SLICE_LEN (SLICE_LEN),
        .HI_FIRST  (HI_FIRST)
    ) u_select (
        .word  (data_d),
        .k     (k_d),
        .slice (sel_slice)
    );

    always_comb begin
        busy_d      = (state_d == BUSY);
        out_data_d  = busy_d ? sel_slice : '0;
        out_index_d = busy_d ? k_d : '0;
        out_last_d  = busy_d && (k_d == K_LAST);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            k_q         <= '0;
            out_data_q  <= '0;
            out_index_q <= '0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            out_data_q  <= out_data_d;
            out_index_q <= out_index_d;
            out_last_q  <= out_last_d;
        end
    end

    always_ff @(posedge clk) begin
        data_q <= data_d;
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == BUSY);
    assign out_data  = out_data_q;
    assign out_index = out_index_q;
    assign out_last  = out_last_q;

`ifdef SLICE_STREAMER_PARITY_EN
    logic out_parity_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_parity_q <= 1'b0;
        end else begin
            out_parity_q <= ^out_data_d;
        end
    end

    assign out_parity = out_parity_q;
`endif

endmodule

// File: tb/tb_slice_streamer.sv
// Directed bench for slice_streamer: four parameterisations, table-driven stream and stall
// vectors, then hand sequences for reversed ranges, NUM==1, parity and mid-word reset.
module tb_slice_streamer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, out_ready;

    logic       iv0, ir0, ov0, ol0;
    logic [7:0] id0;
    logic [1:0] od0;
    logic [2:0] oi0;

    logic       iv1, ir1, ov1, ol1;
    logic [0:7] id1;
    logic [3:0] od1;
    logic [1:0] oi1;

    logic       iv2, ir2, ov2, ol2;
    logic [3:3] id2;
    logic [0:0] od2;
    logic [0:0] oi2;

    logic       iv3, ir3, ov3, ol3;
    logic [7:0] id3;
    logic [3:0] od3;
    logic [1:0] oi3;
`ifdef SLICE_STREAMER_PARITY_EN
    logic       op3;
`endif

    slice_streamer #(.LEFT(7), .RIGHT(0), .SLICE_LEN(2), .HI_FIRST(0)) u0 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv0), .in_ready(ir0), .in_data(id0),
        .out_valid(ov0), .out_ready(out_ready), .out_data(od0), .out_index(oi0), .out_last(ol0)
`ifdef SLICE_STREAMER_PARITY_EN
        , .out_parity()
`endif
    );

    slice_streamer #(.LEFT(0), .RIGHT(7), .SLICE_LEN(4), .HI_FIRST(1)) u1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .in_data(id1),
        .out_valid(ov1), .out_ready(out_ready), .out_data(od1), .out_index(oi1), .out_last(ol1)
`ifdef SLICE_STREAMER_PARITY_EN
        , .out_parity()
`endif
    );

    slice_streamer #(.LEFT(3), .RIGHT(3), .SLICE_LEN(1), .HI_FIRST(0)) u2 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv2), .in_ready(ir2), .in_data(id2),
        .out_valid(ov2), .out_ready(out_ready), .out_data(od2), .out_index(oi2), .out_last(ol2)
`ifdef SLICE_STREAMER_PARITY_EN
        , .out_parity()
`endif
    );

    slice_streamer #(.LEFT(7), .RIGHT(0), .SLICE_LEN(4), .HI_FIRST(0)) u3 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv3), .in_ready(ir3), .in_data(id3),
        .out_valid(ov3), .out_ready(out_ready), .out_data(od3), .out_index(oi3), .out_last(ol3)
`ifdef SLICE_STREAMER_PARITY_EN
        , .out_parity(op3)
`endif
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       rdy;
        logic       inv;
        logic [7:0] din;
        logic [7:0] exp;
    } vec_t;

    vec_t tbl [17];

    function automatic logic [7:0] mk(input logic v, input logic [1:0] d, input logic [2:0] i,
                                      input logic l, input logic r);
        return {v, d, i, l, r};
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [1:0] exp5a [4];

    initial begin
        rst_n = 1'b0; out_ready = 1'b0;
        iv0 = 1'b0; iv1 = 1'b0; iv2 = 1'b0; iv3 = 1'b0;
        id0 = 8'h00; id1 = 8'h00; id2 = 1'b0; id3 = 8'h00;

        // u0 rows: check {valid,data,index,last,in_ready}, then drive {out_ready,in_valid,in_data}.
        tbl[0]  = '{1'b1, 1'b1, 8'hB4, mk(1'b0, 2'd0, 3'd0, 1'b0, 1'b1)};
        tbl[1]  = '{1'b1, 1'b0, 8'hFF, mk(1'b1, 2'd0, 3'd0, 1'b0, 1'b0)};
        tbl[2]  = '{1'b1, 1'b0, 8'hFF, mk(1'b1, 2'd1, 3'd1, 1'b0, 1'b0)};
        tbl[3]  = '{1'b1, 1'b0, 8'hFF, mk(1'b1, 2'd3, 3'd2, 1'b0, 1'b0)};
        tbl[4]  = '{1'b1, 1'b0, 8'hFF, mk(1'b1, 2'd2, 3'd3, 1'b1, 1'b0)};
        tbl[5]  = '{1'b0, 1'b1, 8'h1B, mk(1'b0, 2'd0, 3'd0, 1'b0, 1'b1)};
        tbl[6]  = '{1'b0, 1'b1, 8'hFF, mk(1'b1, 2'd3, 3'd0, 1'b0, 1'b0)};
        tbl[7]  = '{1'b0, 1'b0, 8'hFF, mk(1'b1, 2'd3, 3'd0, 1'b0, 1'b0)};
        tbl[8]  = '{1'b1, 1'b0, 8'hFF, mk(1'b1, 2'd3, 3'd0, 1'b0, 1'b0)};
        tbl[9]  = '{1'b0, 1'b1, 8'hFF, mk(1'b1, 2'd2, 3'd1, 1'b0, 1'b0)};
        tbl[10] = '{1'b1, 1'b0, 8'hFF, mk(1'b1, 2'd2, 3'd1, 1'b0, 1'b0)};
        tbl[11] = '{1'b0, 1'b0, 8'hFF, mk(1'b1, 2'd1, 3'd2, 1'b0, 1'b0)};
        tbl[12] = '{1'b1, 1'b1, 8'hFF, mk(1'b1, 2'd1, 3'd2, 1'b0, 1'b0)};
        tbl[13] = '{1'b0, 1'b0, 8'hFF, mk(1'b1, 2'd0, 3'd3, 1'b1, 1'b0)};
        tbl[14] = '{1'b1, 1'b0, 8'hFF, mk(1'b1, 2'd0, 3'd3, 1'b1, 1'b0)};
        tbl[15] = '{1'b1, 1'b0, 8'hFF, mk(1'b0, 2'd0, 3'd0, 1'b0, 1'b1)};
        tbl[16] = '{1'b0, 1'b0, 8'hFF, mk(1'b0, 2'd0, 3'd0, 1'b0, 1'b1)};

        exp5a[0] = 2'd2; exp5a[1] = 2'd2; exp5a[2] = 2'd1; exp5a[3] = 2'd1;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_u0", {ov0, od0, oi0, ol0, 1'b0}, mk(1'b0, 2'd0, 3'd0, 1'b0, 1'b0));
        rst_n = 1'b1;
        #1;
        chk("reset_release_in_ready", {7'd0, ir0}, 8'd1);

        for (int i = 0; i < 17; i++) begin
            chk($sformatf("row%0d", i), {ov0, od0, oi0, ol0, ir0}, tbl[i].exp);
            out_ready = tbl[i].rdy;
            iv0 = tbl[i].inv;
            id0 = tbl[i].din;
            step();
        end
        iv0 = 1'b0;

        // Ascending range walked from HI.
        iv1 = 1'b1; id1 = 8'hB4; out_ready = 1'b1;
        step();
        iv1 = 1'b0;
        chk("u1_beat0", {ov1, od1, oi1, ol1}, {1'b1, 4'h2, 2'd0, 1'b0});
        step();
        chk("u1_beat1", {ov1, od1, oi1, ol1}, {1'b1, 4'hD, 2'd1, 1'b1});
        step();
        chk("u1_done", {6'd0, ov1, ir1}, 8'b01);

        // Single-slice word: first beat is also last.
        iv2 = 1'b1; id2 = 1'b1;
        step();
        iv2 = 1'b0;
        chk("u2_one", {4'd0, ov2, od2, oi2, ol2}, {4'd0, 1'b1, 1'b1, 1'b0, 1'b1});
        step();
        chk("u2_done", {6'd0, ov2, ir2}, 8'b01);
        iv2 = 1'b1; id2 = 1'b0;
        step();
        iv2 = 1'b0;
        chk("u2_zero", {4'd0, ov2, od2, oi2, ol2}, {4'd0, 1'b1, 1'b0, 1'b0, 1'b1});
        step();

        // Nibble slices of 8'h71.
        iv3 = 1'b1; id3 = 8'h71;
        step();
        iv3 = 1'b0;
        chk("u3_beat0", {ov3, od3, oi3, ol3}, {1'b1, 4'h1, 2'd0, 1'b0});
`ifdef SLICE_STREAMER_PARITY_EN
        chk("u3_par0", {7'd0, op3}, 8'd1);
`endif
        step();
        chk("u3_beat1", {ov3, od3, oi3, ol3}, {1'b1, 4'h7, 2'd1, 1'b1});
`ifdef SLICE_STREAMER_PARITY_EN
        chk("u3_par1", {7'd0, op3}, 8'd1);
`endif
        step();
        chk("u3_done", {6'd0, ov3, ir3}, 8'b01);
`ifdef SLICE_STREAMER_PARITY_EN
        chk("u3_par_idle", {7'd0, op3}, 8'd0);
`endif

        // Reset asserted mid-word after two beats are taken.
        iv0 = 1'b1; id0 = 8'hC3;
        step();
        iv0 = 1'b0;
        chk("mid_beat0", {ov0, od0, oi0, ol0, ir0}, mk(1'b1, 2'd3, 3'd0, 1'b0, 1'b0));
        step();
        chk("mid_beat1", {ov0, od0, oi0, ol0, ir0}, mk(1'b1, 2'd0, 3'd1, 1'b0, 1'b0));
        step();
        chk("mid_beat2", {ov0, od0, oi0, ol0, ir0}, mk(1'b1, 2'd0, 3'd2, 1'b0, 1'b0));
        rst_n = 1'b0;
        #1;
        chk("mid_async_reset", {ov0, od0, oi0, ol0, 1'b0}, mk(1'b0, 2'd0, 3'd0, 1'b0, 1'b0));
        step();
        step();
        chk("mid_reset_held", {ov0, od0, oi0, ol0, 1'b0}, mk(1'b0, 2'd0, 3'd0, 1'b0, 1'b0));
        rst_n = 1'b1;
        #1;
        chk("mid_release", {6'd0, ov0, ir0}, 8'b01);
        iv0 = 1'b1; id0 = 8'h5A;
        step();
        iv0 = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("w5a_beat%0d", k), {ov0, od0, oi0, ol0, ir0},
                mk(1'b1, exp5a[k], 3'(k), (k == 3), 1'b0));
            step();
        end
        chk("w5a_done", {ov0, od0, oi0, ol0, ir0}, mk(1'b0, 2'd0, 3'd0, 1'b0, 1'b1));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/slice_streamer.md
Name: slice_streamer

Overview:
- Upstream feeder for a range-parameterised slice consumer.
- Accepts one wide word declared over an arbitrary index range [LEFT:RIGHT], which may be ascending or descending.
- Streams the word out as consecutive fixed-width slices over a valid/ready handshake.
- Slice k covers the same index window a consumer would address as xs[LO+k*SLICE_LEN +: SLICE_LEN], or the mirrored -: window when walking from HI.

Parameters:
- LEFT, 7: left bound of the input word's index range.
- RIGHT, 0: right bound of the input word's index range. Either order is legal.
- SLICE_LEN, 2: width of each output slice in bits. Must be ≥1 and must divide LEN.
- HI_FIRST, 0: 0 walks from index LO upward using +:. 1 walks from index HI downward using -:.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input word valid.
- in_ready  out  1  block can accept a word.
- in_data  in  [LEFT:RIGHT]  input word, declared with the literal parameter range.
- out_valid  out  1  slice valid.
- out_ready  in  1  downstream accepts the slice.
- out_data  out  [SLICE_LEN-1:0]  current slice. Bit SLICE_LEN-1 is the highest index of the window.
- out_index  out  $clog2(NUM)+1  ordinal of the current slice, 0..NUM-1.
- out_last  out  1  high on the final slice of the word.

Behaviour:
- Derived localparams:
  - LO = min(LEFT,RIGHT), HI = max(LEFT,RIGHT).
  - LEN = HI-LO+1.
  - NUM = LEN/SLICE_LEN.
- Generate-time error if LEN % SLICE_LEN != 0.
- FSM with two states, IDLE and BUSY. Reset state is IDLE.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid&&in_ready: capture in_data index-for-index into an internal [LEFT:RIGHT] register, clear the slice counter, go to BUSY.
- BUSY:
  - in_ready=0, out_valid=1.
  - out_data is the window for the current counter value k:
    - HI_FIRST=0: base LO+k*SLICE_LEN, +: SLICE_LEN.
    - HI_FIRST=1: base HI-k*SLICE_LEN, -: SLICE_LEN.
  - On out_valid&&out_ready: k increments. If k==NUM-1, return to IDLE instead.
- out_data, out_index and out_last must stay stable while out_valid=1 and out_ready=0.
- out_last = (k==NUM-1). With NUM==1, the first slice is also the last.
- Latency:
  - First slice is valid one cycle after input acceptance.
  - One slice per cycle while out_ready stays high.
  - A full word occupies NUM+1 cycles, including the IDLE accept cycle.
  - No overlap between words: in_ready rises only in the cycle after the last beat is taken.
- Counter width is $clog2(NUM)+1 so NUM=1 still yields a 1-bit counter. The counter never wraps past NUM-1.
- Reset, including assertion mid-word:
  - State forced to IDLE, counter cleared, out_valid=0, out_data=0, out_index=0, out_last=0.
  - in_ready=1 once rst_n deasserts.
  - Captured data is discarded.
- in_data is sampled only in the accept cycle. Changes at any other time have no effect.
- out_ready high while out_valid is low has no effect.

Optional Feature:
- Macro: SLICE_STREAMER_PARITY_EN.
- Defined:
  - Adds output port out_parity (1 bit) = even parity (XOR) of out_data.
  - Valid whenever out_valid=1. 0 in IDLE and at reset.
  - Must follow the same hold-stable rule as out_data.
- Undefined: the port is absent and there is no parity logic.

Decomposition:
- Package slice_pkg:
  - Constant functions range_lo(l,r), range_hi(l,r) and range_len(l,r).
  - typedef enum logic {IDLE, BUSY} stream_state_t.
- One sub-module, slice_select (combinational):
  - Parameters: LEFT, RIGHT, SLICE_LEN, HI_FIRST.
  - Inputs: the [LEFT:RIGHT] word and slice index k.
  - Output: the window. Implemented with +: / -: part-selects.
- slice_streamer instantiates one slice_select and holds the FSM, counter and capture register.

Test Plan:
- LEFT=7, RIGHT=0, SLICE_LEN=2, HI_FIRST=0, in_data=8'hB4, out_ready held 1 → out_data 0,1,3,2 on four consecutive cycles; out_last only on the 4th; in_ready=1 on the next cycle.
- LEFT=0, RIGHT=7, SLICE_LEN=4, HI_FIRST=1, in_data=8'hB4 (index 0=1, …, index 7=0) → slices are indices[7:4] then indices[3:0]; out_data=4'h2 then 4'hD.
- LEFT=3, RIGHT=3, SLICE_LEN=1 → NUM=1; single slice equals in_data; out_last=1 and out_index=0 on the first beat.
- Backpressure: out_ready toggled 0,0,1,0,1… → each slice held unchanged while stalled; no slice skipped or duplicated; in_valid pulses during BUSY are ignored (in_ready=0).
- Reset mid-word: rst_n dropped after the 2nd of 4 beats → out_valid=0 immediately (asynchronous); after release in_ready=1; a new word 8'h5A streams from k=0.
- With SLICE_STREAMER_PARITY_EN, LEFT=7, RIGHT=0, SLICE_LEN=4, in_data=8'h71 → out_data 1 then 7; out_parity 1 then 1.
